mdom_wvb_hdr_reader: RTL and testbench

Read-side counterpart to the waveform-buffer header fan-in. Pops one 79-bit header bundle at a time from the header FIFO and unpacks it into its fields. Serializes the fields as a fixed sequence of 16-bit words on a valid/ready stream toward the readout/DMA arbiter. Sits between the per-channel header FIFO and the channel readout mux.

---
 rtl/mdom_wvb_hdr_pkg.sv | 40 ++++
 rtl/mdom_wvb_hdr_bundle_fan_out.sv | 28 ++
 rtl/mdom_wvb_hdr_reader.sv | 160 ++++++++++++++++
 tb/tb_mdom_wvb_hdr_reader.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdom_wvb_hdr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdom_wvb_hdr_pkg
// Description : Shared constants for the waveform-buffer header reader:
//               bundle width, field widths/offsets, words per header and
//               FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mdom_wvb_hdr_pkg;

    // Bundle geometry (inverse of the header fan-in packing)
    localparam int c_bundle_w  = 79;

    localparam int c_ltc_w     = 49;
    localparam int c_ltc_lsb   = 0;
    localparam int c_start_w   = 11;
    localparam int c_start_lsb = 49;
    localparam int c_stop_w    = 11;
    localparam int c_stop_lsb  = 60;
    localparam int c_trig_w    = 2;
    localparam int c_trig_lsb  = 71;
    localparam int c_cnst_lsb  = 73;
    localparam int c_pre_w     = 5;
    localparam int c_pre_lsb   = 74;

    // Stream geometry
    localparam int c_word_w        = 16;
    localparam int c_n_words_base  = 6;
    localparam int c_n_words_len   = 7;
    localparam int c_widx_w        = 3;

    // Reader FSM encoding
    localparam int         c_state_w  = 2;
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_rd    = 2'd1;
    localparam logic [1:0] c_st_cap   = 2'd2;
    localparam logic [1:0] c_st_send  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/mdom_wvb_hdr_bundle_fan_out.sv
`default_nettype none
// ============================================================================
// Module      : mdom_wvb_hdr_bundle_fan_out
// Description : Purely combinational slicing of a 79-bit header bundle into
//               its fields; exact inverse of the header fan-in.
// Revision    : 1.0 - initial release
// ============================================================================
module mdom_wvb_hdr_bundle_fan_out
    import mdom_wvb_hdr_pkg::*;
(
    input  logic [c_bundle_w-1:0] i_bundle,
    output logic [c_ltc_w-1:0]    o_evt_ltc,
    output logic [c_start_w-1:0]  o_start_addr,
    output logic [c_stop_w-1:0]   o_stop_addr,
    output logic [c_trig_w-1:0]   o_trig_src,
    output logic                  o_cnst_run,
    output logic [c_pre_w-1:0]    o_pre_conf
);

    assign o_evt_ltc    = i_bundle[c_ltc_lsb   +: c_ltc_w];
    assign o_start_addr = i_bundle[c_start_lsb +: c_start_w];
    assign o_stop_addr  = i_bundle[c_stop_lsb  +: c_stop_w];
    assign o_trig_src   = i_bundle[c_trig_lsb  +: c_trig_w];
    assign o_cnst_run   = i_bundle[c_cnst_lsb];
    assign o_pre_conf   = i_bundle[c_pre_lsb   +: c_pre_w];

endmodule
`default_nettype wire

// File: rtl/mdom_wvb_hdr_reader.sv
`default_nettype none
// ============================================================================
// Module      : mdom_wvb_hdr_reader
// Description : Pops one header bundle from the header FIFO, registers its
//               fields and streams them as fixed 16-bit words on a
//               valid/ready interface.
//               Optional macro MDOM_WVB_HDR_LEN_WORD_EN appends a seventh
//               word carrying the waveform length.
// Revision    : 1.0 - initial release
// ============================================================================
module mdom_wvb_hdr_reader
    import mdom_wvb_hdr_pkg::*;
#(
    parameter int N_WORDS_BASE = c_n_words_base
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hdr_empty,
    output logic                  hdr_rdreq,
    input  logic [c_bundle_w-1:0] hdr_bundle,
    output logic [c_word_w-1:0]   dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  dout_last,
    output logic [c_ltc_w-1:0]    evt_ltc,
    output logic [c_start_w-1:0]  start_addr,
    output logic [c_stop_w-1:0]   stop_addr,
    output logic [c_trig_w-1:0]   trig_src,
    output logic                  cnst_run,
    output logic [c_pre_w-1:0]    pre_conf,
    output logic                  busy
);

`ifdef MDOM_WVB_HDR_LEN_WORD_EN
    localparam int c_n_words = N_WORDS_BASE + 1;
`else
    localparam int c_n_words = N_WORDS_BASE;
`endif
    localparam logic [c_widx_w-1:0] c_last_idx = c_widx_w'(c_n_words - 1);

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_state_nxt;
    logic [c_widx_w-1:0]  r_widx;
    logic [c_word_w-1:0]  w_word;

    logic [c_ltc_w-1:0]   w_evt_ltc,    r_evt_ltc;
    logic [c_start_w-1:0] w_start_addr, r_start_addr;
    logic [c_stop_w-1:0]  w_stop_addr,  r_stop_addr;
    logic [c_trig_w-1:0]  w_trig_src,   r_trig_src;
    logic                 w_cnst_run,   r_cnst_run;
    logic [c_pre_w-1:0]   w_pre_conf,   r_pre_conf;

    mdom_wvb_hdr_bundle_fan_out u_fan_out (
        .i_bundle     (hdr_bundle),
        .o_evt_ltc    (w_evt_ltc),
        .o_start_addr (w_start_addr),
        .o_stop_addr  (w_stop_addr),
        .o_trig_src   (w_trig_src),
        .o_cnst_run   (w_cnst_run),
        .o_pre_conf   (w_pre_conf)
    );

    // State register; reset aborts any header in flight
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_st_idle;
        else     r_state <= w_state_nxt;
    end

    // Next state: one FIFO pop per header, leave SEND on last-word transfer
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (!hdr_empty) w_state_nxt = c_st_rd;
            c_st_rd:   w_state_nxt = c_st_cap;
            c_st_cap:  w_state_nxt = c_st_send;
            c_st_send: if (dout_ready && (r_widx == c_last_idx)) w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    // Capture fields in CAP (FIFO data is valid the cycle after rdreq); step word index on transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_widx       <= '0;
            r_evt_ltc    <= '0;
            r_start_addr <= '0;
            r_stop_addr  <= '0;
            r_trig_src   <= '0;
            r_cnst_run   <= 1'b0;
            r_pre_conf   <= '0;
        end else if (r_state == c_st_cap) begin
            r_widx       <= '0;
            r_evt_ltc    <= w_evt_ltc;
            r_start_addr <= w_start_addr;
            r_stop_addr  <= w_stop_addr;
            r_trig_src   <= w_trig_src;
            r_cnst_run   <= w_cnst_run;
            r_pre_conf   <= w_pre_conf;
        end else if ((r_state == c_st_send) && dout_ready) begin
            r_widx <= r_widx + 1'b1;
        end
    end

`ifdef MDOM_WVB_HDR_LEN_WORD_EN
    // 11-bit wrap-around distance, zero-extended before +1 so the range is 1..2048
    logic [c_stop_w-1:0] w_len_diff;
    logic [11:0]         w_wfm_len;
    assign w_len_diff = r_stop_addr - r_start_addr;
    assign w_wfm_len  = {1'b0, w_len_diff} + 12'd1;
`endif

    // Word selection from the held field registers; stable while stalled
    always_comb begin
        w_word = '0;
        case (r_widx)
            3'd0:    w_word = {r_pre_conf, r_cnst_run, r_trig_src, 7'b0, r_evt_ltc[48]};
            3'd1:    w_word = r_evt_ltc[47:32];
            3'd2:    w_word = r_evt_ltc[31:16];
            3'd3:    w_word = r_evt_ltc[15:0];
            3'd4:    w_word = {5'b0, r_start_addr};
            3'd5:    w_word = {5'b0, r_stop_addr};
`ifdef MDOM_WVB_HDR_LEN_WORD_EN
            3'd6:    w_word = {4'b0, w_wfm_len};
`endif
            default: w_word = '0;
        endcase
    end

    // Outputs decoded from state only, so dout_valid has no path from dout_ready
    always_comb begin
        hdr_rdreq  = 1'b0;
        dout_valid = 1'b0;
        dout_last  = 1'b0;
        busy       = 1'b0;
        dout       = '0;
        case (r_state)
            c_st_rd: begin
                hdr_rdreq = 1'b1;
                busy      = 1'b1;
            end
            c_st_cap: busy = 1'b1;
            c_st_send: begin
                busy       = 1'b1;
                dout_valid = 1'b1;
                dout       = w_word;
                dout_last  = (r_widx == c_last_idx);
            end
            default: ;
        endcase
    end

    assign evt_ltc    = r_evt_ltc;
    assign start_addr = r_start_addr;
    assign stop_addr  = r_stop_addr;
    assign trig_src   = r_trig_src;
    assign cnst_run   = r_cnst_run;
    assign pre_conf   = r_pre_conf;

endmodule
`default_nettype wire

// File: tb/tb_mdom_wvb_hdr_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mdom_wvb_hdr_reader
// Description : Directed self-checking bench for mdom_wvb_hdr_reader with a
//               normal-mode FIFO model and a stream monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdom_wvb_hdr_reader;

`ifdef MDOM_WVB_HDR_LEN_WORD_EN
    localparam int c_n = 7;
`else
    localparam int c_n = 6;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hdr_empty;
    logic        hdr_rdreq;
    logic [78:0] hdr_bundle = '0;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_ready = 1'b1;
    logic        dout_last;
    logic [48:0] evt_ltc;
    logic [10:0] start_addr;
    logic [10:0] stop_addr;
    logic [1:0]  trig_src;
    logic        cnst_run;
    logic [4:0]  pre_conf;
    logic        busy;

    mdom_wvb_hdr_reader dut (
        .clk        (clk),
        .rst        (rst),
        .hdr_empty  (hdr_empty),
        .hdr_rdreq  (hdr_rdreq),
        .hdr_bundle (hdr_bundle),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .evt_ltc    (evt_ltc),
        .start_addr (start_addr),
        .stop_addr  (stop_addr),
        .trig_src   (trig_src),
        .cnst_run   (cnst_run),
        .pre_conf   (pre_conf),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // FIFO model: the writer owns wr_ptr, the reader process owns rd_ptr
    logic [78:0] r_mem [0:15];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign hdr_empty = (wr_ptr == rd_ptr);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          rdreq_cnt  = 0;
    int          rdreq_bad  = 0;
    int          rdreq_cyc [0:15];
    logic [15:0] rx_word [0:255];
    logic        rx_last [0:255];
    int          rx_n       = 0;
    int          hold_err   = 0;
    logic        held       = 1'b0;
    logic [15:0] held_dout  = '0;
    logic        held_last  = 1'b0;

    // FIFO read side and stream monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (hdr_rdreq) begin
            if (hdr_empty) rdreq_bad++;
            hdr_bundle = r_mem[rd_ptr % 16];
            rdreq_cyc[rdreq_cnt % 16] = cyc;
            rd_ptr++;
            rdreq_cnt++;
        end
        if (held && dout_valid && ((dout !== held_dout) || (dout_last !== held_last))) hold_err++;
        held      = dout_valid && !dout_ready;
        held_dout = dout;
        held_last = dout_last;
        if (dout_valid && dout_ready) begin
            rx_word[rx_n % 256] = dout;
            rx_last[rx_n % 256] = dout_last;
            rx_n++;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_hdr(input logic [78:0] b);
        r_mem[wr_ptr % 16] = b;
        wr_ptr++;
    endtask

    function automatic logic [78:0] mk_bundle(input logic [48:0] ltc, input logic [10:0] start,
                                              input logic [10:0] stop, input logic [1:0] trig,
                                              input logic cnst, input logic [4:0] pre);
        return {pre, cnst, trig, stop, start, ltc};
    endfunction

    task automatic wait_rx(input string tag, input int target);
        int k = 0;
        while ((rx_n < target) && (k < 300)) begin
            tick();
            k++;
        end
        check_val({tag, "_rx_timeout"}, 64'(rx_n >= target), 64'd1);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while ((busy || !hdr_empty) && (k < 300)) begin
            tick();
            k++;
        end
        check_val({tag, "_idle_timeout"}, 64'(!busy && hdr_empty), 64'd1);
    endtask

    // Words packed MSB-first: word i at [111-16*i -: 16]; word 6 only used with the length word
    task automatic check_hdr(input string tag, input int base, input logic [111:0] exp);
        for (int i = 0; i < c_n; i++) begin
            check_val($sformatf("%s_w%0d", tag, i), 64'(rx_word[(base + i) % 256]), 64'(exp[111 - 16*i -: 16]));
            check_val($sformatf("%s_last%0d", tag, i), 64'(rx_last[(base + i) % 256]), 64'(i == c_n - 1));
        end
    endtask

    // Header A: pre=10101 cnst=1 trig=10 ltc[48]=1 -> 1010_1110_0000_0001 = AE01
    localparam logic [111:0] c_exp_a = {16'hAE01, 16'h2345, 16'h6789, 16'hABCD, 16'h0010, 16'h001F, 16'h0010};
    // Header B: pre=11111 cnst=0 trig=01 ltc[48]=0 -> 1111_1001_0000_0000 = F900; len 7FF-0+1
    localparam logic [111:0] c_exp_b = {16'hF900, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h07FF, 16'h0800};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [78:0] hdr_a, hdr_b;
        int base, base2, lat, rq0, bad;

        hdr_a = mk_bundle(49'h1_2345_6789_ABCD, 11'h010, 11'h01F, 2'd2, 1'b1, 5'h15);
        hdr_b = mk_bundle(49'h0_0000_0000_0001, 11'h000, 11'h7FF, 2'd1, 1'b0, 5'h1F);

        // Reset state
        repeat (3) tick();
        check_val("rst_rdreq", 64'(hdr_rdreq), 64'd0);
        check_val("rst_dout", 64'(dout), 64'd0);
        check_val("rst_valid", 64'(dout_valid), 64'd0);
        check_val("rst_last", 64'(dout_last), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_fields", 64'({evt_ltc, start_addr, stop_addr, trig_src, cnst_run, pre_conf} != '0), 64'd0);
        rst = 1'b0;
        tick();

        // Single header: latency, fields, word sequence
        base = rx_n;
        rq0  = rdreq_cnt;
        push_hdr(hdr_a);
        lat = 0;
        while (!dout_valid && (lat < 20)) begin
            tick();
            lat++;
        end
        check_val("latency", 64'(lat), 64'd3);
        check_val("f_ltc", 64'(evt_ltc), 64'h1_2345_6789_ABCD);
        check_val("f_start", 64'(start_addr), 64'h010);
        check_val("f_stop", 64'(stop_addr), 64'h01F);
        check_val("f_trig", 64'(trig_src), 64'd2);
        check_val("f_cnst", 64'(cnst_run), 64'd1);
        check_val("f_pre", 64'(pre_conf), 64'h15);
        wait_rx("single", base + c_n);
        wait_idle("single");
        check_hdr("single", base, c_exp_a);
        check_val("single_rdreqs", 64'(rdreq_cnt - rq0), 64'd1);

        // Backpressure on word 2 while a second header waits in the FIFO
        base = rx_n;
        push_hdr(hdr_a);
        push_hdr(hdr_b);
        wait_rx("bp_pre", base + 2);
        dout_ready = 1'b0;
        rq0 = rdreq_cnt;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val($sformatf("bp_dout%0d", i), 64'(dout), 64'h6789);
            check_val($sformatf("bp_valid%0d", i), 64'(dout_valid), 64'd1);
            check_val($sformatf("bp_rdreq%0d", i), 64'(hdr_rdreq), 64'd0);
        end
        check_val("bp_no_read", 64'(rdreq_cnt - rq0), 64'd0);
        dout_ready = 1'b1;
        wait_rx("bp", base + 2*c_n);
        wait_idle("bp");
        check_hdr("bp_a", base, c_exp_a);
        check_hdr("bp_b", base + c_n, c_exp_b);

`ifdef MDOM_WVB_HDR_LEN_WORD_EN
        // Length wrap-around cases
        base = rx_n;
        push_hdr(mk_bundle(49'h0, 11'd2040, 11'd7,   2'd0, 1'b0, 5'h0));
        push_hdr(mk_bundle(49'h0, 11'd100,  11'd100, 2'd0, 1'b0, 5'h0));
        push_hdr(mk_bundle(49'h0, 11'd5,    11'd4,   2'd0, 1'b0, 5'h0));
        wait_rx("len", base + 3*c_n);
        wait_idle("len");
        check_val("len_wrap", 64'(rx_word[(base + 6) % 256]), 64'h0010);
        check_val("len_equal", 64'(rx_word[(base + c_n + 6) % 256]), 64'h0001);
        check_val("len_full", 64'(rx_word[(base + 2*c_n + 6) % 256]), 64'h0800);
`endif

        // Back-to-back: three queued headers, FIFO order, period of N+3 cycles
        base = rx_n;
        rq0  = rdreq_cnt;
        push_hdr(mk_bundle(49'h1111, 11'h0, 11'h0, 2'd0, 1'b0, 5'h0));
        push_hdr(mk_bundle(49'h2222, 11'h0, 11'h0, 2'd0, 1'b0, 5'h0));
        push_hdr(mk_bundle(49'h3333, 11'h0, 11'h0, 2'd0, 1'b0, 5'h0));
        wait_rx("b2b", base + 3*c_n);
        wait_idle("b2b");
        check_val("b2b_rdreqs", 64'(rdreq_cnt - rq0), 64'd3);
        check_val("b2b_period1", 64'(rdreq_cyc[(rq0 + 1) % 16] - rdreq_cyc[rq0 % 16]), 64'(c_n + 3));
        check_val("b2b_period2", 64'(rdreq_cyc[(rq0 + 2) % 16] - rdreq_cyc[(rq0 + 1) % 16]), 64'(c_n + 3));
        check_val("b2b_h0", 64'(rx_word[(base + 3) % 256]), 64'h1111);
        check_val("b2b_h1", 64'(rx_word[(base + c_n + 3) % 256]), 64'h2222);
        check_val("b2b_h2", 64'(rx_word[(base + 2*c_n + 3) % 256]), 64'h3333);
        check_val("b2b_last0", 64'(rx_last[(base + c_n - 1) % 256]), 64'd1);
        check_val("b2b_last1", 64'(rx_last[(base + 2*c_n - 1) % 256]), 64'd1);

        // Empty FIFO: nothing moves
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (hdr_rdreq || dout_valid || busy) bad++;
        end
        check_val("empty_quiet", 64'(bad), 64'd0);

        // Reset during word 3, then the next queued header starts cleanly
        base = rx_n;
        rq0  = rdreq_cnt;
        push_hdr(hdr_a);
        push_hdr(hdr_b);
        wait_rx("mrst_pre", base + 3);
        check_val("mrst_word3", 64'(dout), 64'hABCD);
        rst = 1'b1;
        tick();
        check_val("mrst_valid", 64'(dout_valid), 64'd0);
        check_val("mrst_dout", 64'(dout), 64'd0);
        check_val("mrst_last", 64'(dout_last), 64'd0);
        check_val("mrst_busy", 64'(busy), 64'd0);
        check_val("mrst_rdreq", 64'(hdr_rdreq), 64'd0);
        check_val("mrst_fields", 64'({evt_ltc, start_addr, stop_addr, trig_src, cnst_run, pre_conf} != '0), 64'd0);
        rst = 1'b0;
        check_val("mrst_reads", 64'(rdreq_cnt - rq0), 64'd1);
        base2 = rx_n;
        wait_rx("mrst", base2 + c_n);
        wait_idle("mrst");
        check_hdr("mrst_b", base2, c_exp_b);
        check_val("mrst_reads_end", 64'(rdreq_cnt - rq0), 64'd2);

        // Global protocol observations
        check_val("hold_stable", 64'(hold_err), 64'd0);
        check_val("rdreq_when_empty", 64'(rdreq_bad), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
